// File: rtl/datapath_pkg.sv
// datapath_pkg: opcodes, IR field positions, CON condition codes and bus source priority.
// Revision 1.0
`default_nettype none

package datapath_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_BRX  = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_JAL  = 5'b10100;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RA_HI  = 26;
   localparam int RA_LO  = 23;
   localparam int RB_HI  = 22;
   localparam int RB_LO  = 19;
   localparam int RC_HI  = 18;
   localparam int RC_LO  = 15;
   localparam int C_HI   = 18;
   localparam int C2_HI  = 20;
   localparam int C2_LO  = 19;

   typedef enum logic [1:0] {
      C2_ZERO    = 2'b00,
      C2_NONZERO = 2'b01,
      C2_POS     = 2'b10,
      C2_NEG     = 2'b11
   } cond_t;

   // Enumeration order is the bus arbitration priority, highest first.
   typedef enum logic [3:0] {
      BUS_NONE, BUS_MDR, BUS_PC, BUS_ZLO, BUS_ZHI, BUS_LO,
      BUS_HI, BUS_INPORT, BUS_C, BUS_Y, BUS_REG
   } bus_src_t;

   function automatic logic cond_met(input logic [1:0] c2, input logic [31:0] v);
      case (cond_t'(c2))
         C2_ZERO:    cond_met = (v == 32'd0);
         C2_NONZERO: cond_met = (v != 32'd0);
         C2_POS:     cond_met = !v[31] && (v != 32'd0);
         default:    cond_met = v[31];
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/datapath_alu.sv
// alu: combinational 64-bit result from A (Y) and B (bus) selected by IR opcode.
// Revision 1.0
`default_nettype none

module alu
   import datapath_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result
);

   logic signed [63:0] a64, b64, prod;
   logic [31:0] quo, rem, ror_v, rol_v;
   logic [4:0]  sh;

   assign sh    = b[4:0];
   assign a64   = {{32{a[31]}}, a};
   assign b64   = {{32{b[31]}}, b};
   assign prod  = a64 * b64;
   assign ror_v = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
   assign rol_v = (a << sh) | (a >> (6'd32 - {1'b0, sh}));

   // Divide by zero returns all-ones quotient and passes the dividend as remainder.
   always_comb begin
      quo = '1;
      rem = a;
      if (b != 32'd0) begin
         quo = $signed(a) / $signed(b);
         rem = $signed(a) % $signed(b);
      end
   end

   always_comb begin
      result = {32'd0, a + b};
      case (op)
         OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_BRX, OP_JR, OP_JAL, OP_ADD:
                          result = {32'd0, a + b};
         OP_SUB:          result = {32'd0, a - b};
         OP_SHR:          result = {32'd0, a >> sh};
         OP_SHL:          result = {32'd0, a << sh};
         OP_ROR:          result = {32'd0, ror_v};
         OP_ROL:          result = {32'd0, rol_v};
         OP_AND, OP_ANDI: result = {32'd0, a & b};
         OP_OR, OP_ORI:   result = {32'd0, a | b};
         OP_MUL:          result = prod;
         OP_DIV:          result = {rem, quo};
         OP_NEG:          result = {32'd0, -b};
         OP_NOT:          result = {32'd0, ~b};
         default:         result = {32'd0, a + b};
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/datapath.sv
// datapath: single-bus CPU datapath with register file, memory interface, ALU and I/O ports.
// Revision 1.0
`default_nettype none

module datapath
   import datapath_pkg::*;
(
   input  logic        Clock,
   input  logic        Clear,
   output logic [31:0] OutPort_output,
   input  logic        IncPC,
   input  logic        CONin,
   input  logic        RAM_write,
   input  logic        MDR_enable,
   input  logic        MDRout,
   input  logic        MAR_enable,
   input  logic        IR_enable,
   input  logic        MDR_read,
   input  logic        Gra,
   input  logic        Grb,
   input  logic        Grc,
   input  logic        HI_enable,
   input  logic        LO_enable,
   input  logic        ZHighIn,
   input  logic        ZLowIn,
   input  logic        Y_enable,
   input  logic        PC_enable,
   input  logic        OutPort_enable,
   input  logic        InPortout,
   input  logic        PCout,
   input  logic        Yout,
   input  logic        ZLowout,
   input  logic        ZHighout,
   input  logic        LOout,
   input  logic        HIout,
   input  logic        BAout,
   input  logic        Cout,
   input  logic [31:0] InPort_input,
   input  logic [31:0] Mdatain,
   input  logic        R_in,
   input  logic        R_out,
   input  logic        Cin
);

   logic [31:0] regs [16];
   logic [31:0] pc, ir, mdr, y, hi, lo, zhigh, zlow, inport, outport;
   logic [8:0]  mar;
   logic        con;
   logic [31:0] ram [512];

   logic [31:0] bus, c_ext;
   logic [63:0] alu_res;
   logic [3:0]  sel;
   bus_src_t    src;

   logic unused_inputs;
   assign unused_inputs = &{1'b0, Mdatain, Cin};

   assign sel = ({4{Gra}} & ir[RA_HI:RA_LO]) |
                ({4{Grb}} & ir[RB_HI:RB_LO]) |
                ({4{Grc}} & ir[RC_HI:RC_LO]);
   assign c_ext = {{13{ir[C_HI]}}, ir[C_HI:0]};
   assign OutPort_output = outport;

   always_comb begin
      src = BUS_NONE;
      if      (MDRout)         src = BUS_MDR;
      else if (PCout)          src = BUS_PC;
      else if (ZLowout)        src = BUS_ZLO;
      else if (ZHighout)       src = BUS_ZHI;
      else if (LOout)          src = BUS_LO;
      else if (HIout)          src = BUS_HI;
      else if (InPortout)      src = BUS_INPORT;
      else if (Cout)           src = BUS_C;
      else if (Yout)           src = BUS_Y;
      else if (R_out || BAout) src = BUS_REG;
   end

   // BAout treats R0 as a constant zero base; R_out always reads the register.
   always_comb begin
      bus = '0;
      case (src)
         BUS_MDR:    bus = mdr;
         BUS_PC:     bus = pc;
         BUS_ZLO:    bus = zlow;
         BUS_ZHI:    bus = zhigh;
         BUS_LO:     bus = lo;
         BUS_HI:     bus = hi;
         BUS_INPORT: bus = inport;
         BUS_C:      bus = c_ext;
         BUS_Y:      bus = y;
         BUS_REG:    bus = (R_out || sel != 4'd0) ? regs[sel] : '0;
         default:    bus = '0;
      endcase
   end

   alu u_alu (
      .op     (ir[OPC_HI:OPC_LO]),
      .a      (y),
      .b      (bus),
      .result (alu_res)
   );

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         for (int i = 0; i < 16; i++) regs[i] <= '0;
         pc      <= '0;
         ir      <= '0;
         mar     <= '0;
         mdr     <= '0;
         y       <= '0;
         hi      <= '0;
         lo      <= '0;
         zhigh   <= '0;
         zlow    <= '0;
         inport  <= '0;
         outport <= '0;
         con     <= 1'b0;
      end else begin
         if (R_in)           regs[sel] <= bus;
         if (PC_enable)      pc <= IncPC ? pc + 32'd1 : bus;
         if (IR_enable)      ir <= bus;
         if (MAR_enable)     mar <= bus[8:0];
         if (MDR_enable)     mdr <= MDR_read ? ram[mar] : bus;
         if (Y_enable)       y <= bus;
         if (HI_enable)      hi <= bus;
         if (LO_enable)      lo <= bus;
         if (ZHighIn)        zhigh <= alu_res[63:32];
         if (ZLowIn)         zlow <= alu_res[31:0];
         if (OutPort_enable) outport <= bus;
         if (CONin)          con <= cond_met(ir[C2_HI:C2_LO], bus);
         inport <= InPort_input;
      end
   end

   // Memory array is not reset; writes are suppressed while Clear is held low.
   always_ff @(posedge Clock) begin
      if (RAM_write && Clear) ram[mar] <= mdr;
   end

endmodule

`default_nettype wire

// File: tb/tb_datapath.sv
// tb_datapath: directed self-checking bench for the datapath block.
// Revision 1.0
`default_nettype none

module tb_datapath;

   logic        Clock = 1'b0;
   logic        Clear = 1'b0;
   logic [31:0] OutPort_output;
   logic IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read;
   logic Gra, Grb, Grc, HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable, OutPort_enable;
   logic InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, BAout, Cout;
   logic R_in, R_out, Cin;
   logic [31:0] InPort_input = '0;
   logic [31:0] Mdatain = '0;

   int n_cmp = 0;
   int n_bad = 0;

   datapath dut (
      .Clock(Clock), .Clear(Clear), .OutPort_output(OutPort_output),
      .IncPC(IncPC), .CONin(CONin), .RAM_write(RAM_write),
      .MDR_enable(MDR_enable), .MDRout(MDRout), .MAR_enable(MAR_enable),
      .IR_enable(IR_enable), .MDR_read(MDR_read),
      .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .HI_enable(HI_enable), .LO_enable(LO_enable), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
      .Y_enable(Y_enable), .PC_enable(PC_enable), .OutPort_enable(OutPort_enable),
      .InPortout(InPortout), .PCout(PCout), .Yout(Yout), .ZLowout(ZLowout),
      .ZHighout(ZHighout), .LOout(LOout), .HIout(HIout), .BAout(BAout), .Cout(Cout),
      .InPort_input(InPort_input), .Mdatain(Mdatain),
      .R_in(R_in), .R_out(R_out), .Cin(Cin)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      {IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read} = '0;
      {Gra, Grb, Grc, HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable, OutPort_enable} = '0;
      {InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, BAout, Cout, R_in, R_out, Cin} = '0;
   endtask

   // Present v on the bus through the input port; the caller adds load strobes and ticks.
   task automatic put(input logic [31:0] v);
      InPort_input = v;
      tick();
      InPortout = 1'b1;
   endtask

   task automatic load_ir(input logic [31:0] v);
      put(v); IR_enable = 1'b1; tick(); idle();
   endtask

   task automatic load_y(input logic [31:0] v);
      put(v); Y_enable = 1'b1; tick(); idle();
   endtask

   task automatic test_reset();
      logic [31:0] obs [13];
      string       nm  [13];
      Clear = 1'b0; idle(); tick(); Clear = 1'b1; tick();
      put(32'hDEADBEEF);
      {OutPort_enable, PC_enable, Y_enable, IR_enable, LO_enable, HI_enable} = '1;
      {MAR_enable, MDR_enable, ZLowIn, ZHighIn, CONin, R_in} = '1;
      tick();
      n_cmp++;
      if (OutPort_output !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL reset_preload: got %h want %h", OutPort_output, 32'hDEADBEEF);
      end
      Clear = 1'b0;
      #2;
      for (int k = 0; k < 2; k++) begin
         obs[0] = OutPort_output; nm[0] = "outport";
         obs[1] = dut.pc;         nm[1] = "pc";
         obs[2] = dut.ir;         nm[2] = "ir";
         obs[3] = {23'd0, dut.mar}; nm[3] = "mar";
         obs[4] = dut.mdr;        nm[4] = "mdr";
         obs[5] = dut.y;          nm[5] = "y";
         obs[6] = dut.zlow;       nm[6] = "zlow";
         obs[7] = dut.zhigh;      nm[7] = "zhigh";
         obs[8] = dut.hi;         nm[8] = "hi";
         obs[9] = dut.lo;         nm[9] = "lo";
         obs[10] = dut.inport;    nm[10] = "inport";
         obs[11] = {31'd0, dut.con}; nm[11] = "con";
         obs[12] = dut.regs[0];   nm[12] = "r0";
         for (int i = 0; i < 13; i++) begin
            n_cmp++;
            if (obs[i] !== 32'd0) begin
               n_bad++; $display("FAIL reset_%s: got %h want %h", nm[i], obs[i], 32'd0);
            end
         end
         for (int r = 1; r < 16; r++) begin
            n_cmp++;
            if (dut.regs[r] !== 32'd0) begin
               n_bad++; $display("FAIL reset_r%0d: got %h want %h", r, dut.regs[r], 32'd0);
            end
         end
         tick();
      end
      idle();
      Clear = 1'b1;
      tick();
   endtask

   task automatic test_fetch();
      put(32'h59080002); MDR_enable = 1'b1; tick(); idle();
      RAM_write = 1'b1; tick(); idle();
      put(32'h11111111); MDR_enable = 1'b1; tick(); idle();
      PCout = 1'b1; MAR_enable = 1'b1; tick(); idle();
      MDR_read = 1'b1; MDR_enable = 1'b1; tick(); idle();
      n_cmp++;
      if (dut.mdr !== 32'h59080002) begin
         n_bad++; $display("FAIL fetch_mdr: got %h want %h", dut.mdr, 32'h59080002);
      end
      MDRout = 1'b1; IR_enable = 1'b1; IncPC = 1'b1; PC_enable = 1'b1; tick(); idle();
      n_cmp++;
      if (dut.ir !== 32'h59080002) begin
         n_bad++; $display("FAIL fetch_ir: got %h want %h", dut.ir, 32'h59080002);
      end
      n_cmp++;
      if (dut.pc !== 32'd1) begin
         n_bad++; $display("FAIL fetch_pc: got %h want %h", dut.pc, 32'd1);
      end
   endtask

   task automatic test_addi();
      put(32'd5); Grb = 1'b1; R_in = 1'b1; tick(); idle();
      n_cmp++;
      if (dut.regs[1] !== 32'd5) begin
         n_bad++; $display("FAIL addi_r1: got %h want %h", dut.regs[1], 32'd5);
      end
      Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1; tick(); idle();
      Cout = 1'b1; ZLowIn = 1'b1; tick(); idle();
      n_cmp++;
      if (dut.zlow !== 32'd7) begin
         n_bad++; $display("FAIL addi_zlow: got %h want %h", dut.zlow, 32'd7);
      end
      ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; tick(); idle();
      n_cmp++;
      if (dut.regs[2] !== 32'd7) begin
         n_bad++; $display("FAIL addi_r2: got %h want %h", dut.regs[2], 32'd7);
      end
   endtask

   task automatic test_mflo_baout();
      put(32'h00001234); LO_enable = 1'b1; tick(); idle();
      load_ir(32'hC1800000);
      Gra = 1'b1; R_in = 1'b1; LOout = 1'b1; tick(); idle();
      n_cmp++;
      if (dut.regs[3] !== 32'h00001234) begin
         n_bad++; $display("FAIL mflo_r3: got %h want %h", dut.regs[3], 32'h00001234);
      end
      load_ir(32'hC0000000);
      put(32'h55); Gra = 1'b1; R_in = 1'b1; tick(); idle();
      Gra = 1'b1; R_out = 1'b1; OutPort_enable = 1'b1; tick(); idle();
      n_cmp++;
      if (OutPort_output !== 32'h55) begin
         n_bad++; $display("FAIL rout_r0: got %h want %h", OutPort_output, 32'h55);
      end
      Gra = 1'b1; BAout = 1'b1; OutPort_enable = 1'b1; tick(); idle();
      n_cmp++;
      if (OutPort_output !== 32'h0) begin
         n_bad++; $display("FAIL baout_r0: got %h want %h", OutPort_output, 32'h0);
      end
      load_ir(32'hC1800000);
      Gra = 1'b1; BAout = 1'b1; OutPort_enable = 1'b1; tick(); idle();
      n_cmp++;
      if (OutPort_output !== 32'h00001234) begin
         n_bad++; $display("FAIL baout_r3: got %h want %h", OutPort_output, 32'h00001234);
      end
   endtask

   task automatic test_alu();
      logic [31:0] t_ir [16] = '{32'h18000000, 32'h20000000, 32'h28000000, 32'h30000000,
                                 32'h38000000, 32'h40000000, 32'h60000000, 32'h50000000,
                                 32'h80000000, 32'h88000000, 32'h70000000, 32'h78000000,
                                 32'h78000000, 32'h78000000, 32'hC0000000, 32'hA0000000};
      logic [31:0] t_y  [16] = '{32'hFFFFFFFF, 32'd3, 32'h80000000, 32'd3,
                                 32'd1, 32'h80000001, 32'hF0F0F0F0, 32'hF0000000,
                                 32'h12345678, 32'd0, 32'hFFFFFFFD, 32'd7,
                                 32'd7, 32'hFFFFFFF9, 32'h10, 32'd1};
      logic [31:0] t_b  [16] = '{32'd2, 32'd5, 32'd4, 32'h21,
                                 32'd1, 32'd4, 32'h0FF00FF0, 32'h0000000F,
                                 32'd5, 32'h0000FFFF, 32'd7, 32'hFFFFFFFE,
                                 32'd0, 32'd2, 32'h20, 32'd1};
      logic [63:0] t_z  [16] = '{64'h00000000_00000001, 64'h00000000_FFFFFFFE,
                                 64'h00000000_08000000, 64'h00000000_00000006,
                                 64'h00000000_80000000, 64'h00000000_00000018,
                                 64'h00000000_00F000F0, 64'h00000000_F000000F,
                                 64'h00000000_FFFFFFFB, 64'h00000000_FFFF0000,
                                 64'hFFFFFFFF_FFFFFFEB, 64'h00000001_FFFFFFFD,
                                 64'h00000007_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFD,
                                 64'h00000000_00000030, 64'h00000000_00000002};
      logic [63:0] z;
      for (int i = 0; i < 16; i++) begin
         load_ir(t_ir[i]);
         load_y(t_y[i]);
         put(t_b[i]); ZLowIn = 1'b1; ZHighIn = 1'b1; tick(); idle();
         z = {dut.zhigh, dut.zlow};
         n_cmp++;
         if (z !== t_z[i]) begin
            n_bad++; $display("FAIL alu_%0d op=%h: got %h want %h", i, t_ir[i][31:27], z, t_z[i]);
         end
      end
   endtask

   task automatic test_con_outport();
      logic [31:0] c_ir  [6] = '{32'h0, 32'h0, 32'h00180000, 32'h00100000, 32'h00100000, 32'h00080000};
      logic [31:0] c_bus [6] = '{32'h0, 32'h5, 32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h0};
      logic        c_exp [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         load_ir(c_ir[i]);
         put(c_bus[i]); CONin = 1'b1; tick(); idle();
         n_cmp++;
         if (dut.con !== c_exp[i]) begin
            n_bad++; $display("FAIL con_%0d: got %b want %b", i, dut.con, c_exp[i]);
         end
      end
      put(32'hA5); OutPort_enable = 1'b1;
      n_cmp++;
      if (OutPort_output !== 32'h00001234) begin
         n_bad++; $display("FAIL outport_before_edge: got %h want %h", OutPort_output, 32'h00001234);
      end
      tick(); idle();
      n_cmp++;
      if (OutPort_output !== 32'hA5) begin
         n_bad++; $display("FAIL outport_load: got %h want %h", OutPort_output, 32'hA5);
      end
   endtask

   task automatic test_back_to_back();
      PCout = 1'b1; PC_enable = 1'b1; IncPC = 1'b1; OutPort_enable = 1'b1; tick(); idle();
      n_cmp++;
      if (OutPort_output !== 32'd1) begin
         n_bad++; $display("FAIL b2b_old_pc: got %h want %h", OutPort_output, 32'd1);
      end
      n_cmp++;
      if (dut.pc !== 32'd2) begin
         n_bad++; $display("FAIL b2b_pc: got %h want %h", dut.pc, 32'd2);
      end
   endtask

   task automatic test_reset_midseq();
      put(32'h42); Y_enable = 1'b1; PC_enable = 1'b1; OutPort_enable = 1'b1;
      Clear = 1'b0; #2; idle(); tick(); Clear = 1'b1; tick();
      n_cmp++;
      if ({dut.pc, dut.y, OutPort_output, dut.ir} !== 128'd0) begin
         n_bad++; $display("FAIL midseq_zero: pc=%h y=%h out=%h ir=%h want 0", dut.pc, dut.y, OutPort_output, dut.ir);
      end
      PCout = 1'b1; MAR_enable = 1'b1; tick(); idle();
      MDR_read = 1'b1; MDR_enable = 1'b1; tick(); idle();
      MDRout = 1'b1; IR_enable = 1'b1; IncPC = 1'b1; PC_enable = 1'b1; tick(); idle();
      n_cmp++;
      if (dut.ir !== 32'h59080002) begin
         n_bad++; $display("FAIL midseq_ir: got %h want %h", dut.ir, 32'h59080002);
      end
      n_cmp++;
      if (dut.pc !== 32'd1) begin
         n_bad++; $display("FAIL midseq_pc: got %h want %h", dut.pc, 32'd1);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_fetch();
      test_addi();
      test_mflo_baout();
      test_alu();
      test_con_outport();
      test_back_to_back();
      test_reset_midseq();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Ports in order; 1-bit unless stated.
- Clock  in  1  sole clock; rising edge.
- Clear  in  1  asynchronous, active-low reset.
- OutPort_output  out  32  output-port register.
- IncPC, CONin, RAM_write  in  PC increment, CON latch, RAM write strobe.
- MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read  in  memory-side load/drive/select strobes.
- Gra, Grb, Grc  in  select IR Ra/Rb/Rc field for the register file.
- HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable, OutPort_enable  in  register load enables.
- InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, BAout, Cout  in  bus drive selects.
- InPort_input  in  32  external input-port data.
- Mdatain  in  32  reserved; ignored in this revision.
- R_in, R_out  in  register-file write/drive using the Gr* selection.
- Cin  in  reserved; ignored.

Function
REQ-002 A single 32-bit bus is formed combinationally from the one driver whose out-select is high; priority if several: MDRout, PCout, ZLowout, ZHighout, LOout, HIout, InPortout, Cout, Yout, R_out/BAout; none high drives 0.
REQ-003 Registers: R0-R15, PC, IR, MAR (9-bit), MDR, Y, HI, LO, Z (64-bit: ZHigh/ZLow), InPort, OutPort, CON (1-bit); each loads the bus on the rising edge when its enable is high.
REQ-004 IR fields: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15], C[18:0], C2[20:19].
REQ-005 Register select = OR of (Gra&Ra, Grb&Rb, Grc&Rc); R_in writes the selected register; R_out drives it; BAout drives it except R0 reads as 0.
REQ-006 Cout drives C sign-extended from bit 18.
REQ-007 PC_enable&IncPC: PC <= PC+1; PC_enable alone: PC <= bus.
REQ-008 Memory: internal 512x32 synchronous RAM addressed by MAR; RAM_write stores MDR at RAM[MAR]; MDR_enable loads RAM[MAR] when MDR_read=1, else the bus.
REQ-009 InPort samples InPort_input every cycle; OutPort_output equals the OutPort register.
REQ-010 ALU, combinational: A=Y, B=bus, 64-bit result, op by IR opcode; ZLowIn loads result[31:0], ZHighIn loads result[63:32].
REQ-011 Opcodes: 00000 ld, 00001 ldi, 00010 st, 01011 addi, 10010 brx, 10011 jr, 10100 jal: A+B; 00011 add; 00100 sub A-B; 00101 shr; 00110 shl; 00111 ror; 01000 rol; 01001/01100 and; 01010/01101 or; 01110 mul; 01111 div; 10000 neg -B; 10001 not ~B; others A+B.
REQ-012 Add/sub/logic are 32-bit, wrap on overflow, high word 0; shift amount B[4:0]; shr logical.
REQ-013 mul: signed 32x32->64; div: signed quotient in low word, remainder (sign of A) in high word; divide by zero gives quotient 0xFFFFFFFF, remainder A.
REQ-014 CON: on CONin, CON <= condition on bus per C2: 00 zero, 01 nonzero, 10 positive (>0), 11 negative.
REQ-015 Simultaneous load and drive of one register in a cycle: drive shows the old value.

Reset
REQ-016 Clear low asynchronously zeroes every register (R0-R15, PC, IR, MAR, MDR, Y, Z, HI, LO, InPort, OutPort, CON); OutPort_output=0 during reset.
REQ-017 RAM contents are not reset; power-up contents are zero unless backdoor-preloaded.
REQ-018 Deasserting Clear mid-sequence resumes from all-zero state; no pending write survives.

Structure
REQ-019 Shared package: opcode constants, IR field positions, C2 condition codes, bus-priority order.
REQ-020 One sub-module, alu, holds REQ-011..013; everything else stays in datapath.

Verification
REQ-021 Reset: Clear=0 with arbitrary strobes -> OutPort_output=0, all registers 0.
REQ-022 Fetch: RAM[0]=0x59080002, PC=0; PCout+MAR_enable; MDR_read+MDR_enable; MDRout+IR_enable with IncPC+PC_enable -> IR=0x59080002, PC=1.
REQ-023 addi: R1=5, IR=0x59080002; Grb+R_out+Y_enable; Cout+ZLowIn; ZLowout+Gra+R_in -> R2=7.
REQ-024 mflo: LO loaded 0x00001234; IR opcode 11000 Ra=3; Gra+R_in+LOout -> R3=0x00001234; BAout with Ra=0 drives 0.
REQ-025 mul Y=-3, B=7 -> Z=0xFFFFFFFF_FFFFFFEB; div Y=7, B=-2 -> ZLow=0xFFFFFFFD, ZHigh=1.
REQ-026 CON: C2=00, bus=0, CONin -> CON=1; bus=5 -> CON=0; OutPort_enable with bus=0xA5 -> OutPort_output=0xA5 next edge.
